riscv_data_mem: RTL and testbench

Multi-cycle data memory with a stall handshake. It sits directly downstream of the datapath's load/store path: it takes the address, store data and funct3 size code, and returns sign- or zero-extended load data. While an access is in flight it holds `stall_o` high so the datapath freezes its PC and register write-back. Internal storage is a little-endian word array with fixed, parameterised access latency.

---
 rtl/riscv_data_mem.sv | 137 +++++++++++++
 tb/tb_riscv_data_mem.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_data_mem.sv
// Multi-cycle little-endian data memory for the load/store path. Holds stall_o
// while an access is in flight and returns sign/zero-extended load data.
module riscv_data_mem #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic [1:0]  state_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // Handshake: a request is taken in IDLE in the same cycle req_i is high and
    // legal; stall_o stays high until the access commits, and DONE (stall_o low)
    // is the single cycle in which rdata_o is valid for the datapath to consume.
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          cap_we;
    logic [2:0]    cap_size;
    logic [AW+1:0] cap_addr;
    logic [31:0]   cap_wdata;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          legal, accept, commit;
    logic [AW-1:0] widx;
    logic [1:0]    lane;
    logic [31:0]   rword, load_val, wdata_rep;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [3:0]    be;
    logic          unused_addr;

    assign unused_addr = ^addr_i[31:AW+2];
    assign state_o     = state_q;

    always_comb begin
        legal = 1'b0;
        case (size_i)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr_i[0];
            3'b010:  legal = (addr_i[1:0] == 2'b00);
            3'b100:  legal = ~we_i;
            3'b101:  legal = ~we_i & ~addr_i[0];
            default: legal = 1'b0;
        endcase
    end

    assign accept     = (state_q == IDLE) & req_i & legal;
    assign misalign_o = (state_q == IDLE) & req_i & ~legal;
    assign stall_o    = accept | (state_q == BUSY);
    assign commit     = (state_q == BUSY) & (cnt_q == CW'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (commit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign widx  = cap_addr[AW+1:2];
    assign lane  = cap_addr[1:0];
    assign rword = mem[widx];
    assign rbyte = rword[{lane, 3'b000} +: 8];
    assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

    // size[2] set means the unsigned load variants
    always_comb begin
        load_val  = rword;
        be        = 4'b1111;
        wdata_rep = cap_wdata;
        case (cap_size[1:0])
            2'b00: begin
                load_val  = {{24{~cap_size[2] & rbyte[7]}}, rbyte};
                be        = 4'b0001 << lane;
                wdata_rep = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                load_val  = {{16{~cap_size[2] & rhalf[15]}}, rhalf};
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{cap_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cap_we    <= 1'b0;
            cap_size  <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata_o   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cap_we    <= we_i;
                cap_size  <= size_i;
                cap_addr  <= addr_i[AW+1:0];
                cap_wdata <= wdata_i;
                cnt_q     <= CW'(LATENCY);
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (commit && !cap_we) rdata_o <= load_val;
        end
    end

    // No reset here: contents survive rst_ni, and reset forces IDLE so an
    // in-flight store never reaches its commit edge.
    always_ff @(posedge clk_i) begin
        if (commit && cap_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_riscv_data_mem.sv
// Randomized scoreboard bench for riscv_data_mem against a byte-array model.
module tb_riscv_data_mem;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
    localparam int BYTES = 4 * DEPTH;

    logic        clk_i, rst_ni, req_i, we_i;
    logic [2:0]  size_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic        stall_o, misalign_o;
    logic [1:0]  unused_state;

    riscv_data_mem #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .we_i(we_i),
        .size_i(size_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .stall_o(stall_o), .misalign_o(misalign_o),
        .state_o(unused_state)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  mm [BYTES];
    logic [31:0] last_rd = '0;
    logic [31:0] exp_q[$];
    logic [31:0] mis_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // reference model
    function automatic bit model_legal(input logic we, input logic [2:0] size, input logic [31:0] addr);
        case (size)
            3'd0: return 1'b1;
            3'd1: return addr % 2 == 0;
            3'd2: return addr % 4 == 0;
            3'd4: return !we;
            3'd5: return !we && (addr % 2 == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic int nbytes(input logic [2:0] size);
        return (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
    endfunction

    task automatic model_store(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int a = int'(addr % BYTES);
        for (int i = 0; i < nbytes(size); i++) mm[a + i] = wdata[8*i +: 8];
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] size, input logic [31:0] addr);
        int          a = int'(addr % BYTES);
        logic [31:0] v = '0;
        int          n = nbytes(size);
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[a + i];
        if (size[2] == 1'b0 && n < 4 && v[8*n-1] == 1'b1)
            v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    // driver: starts #1 after a rising edge in IDLE, returns likewise
    task automatic access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int mode);
        int n;
        we_i = we; size_i = size; addr_i = addr; wdata_i = wdata; req_i = 1'b1;
        if (!model_legal(we, size, addr)) begin
            mis_q.push_back(last_rd);
            @(posedge clk_i); #1;
            req_i = 1'b0;
            return;
        end
        if (we) model_store(size, addr, wdata);
        else last_rd = model_load(size, addr);
        exp_q.push_back(last_rd);
        @(posedge clk_i); #1;
        req_i = 1'b0;
        if (mode == 1) addr_i = addr + 32'd4;
        if (mode == 2) begin
            we_i = 1'($urandom); size_i = 3'($urandom); addr_i = $urandom; wdata_i = $urandom;
        end
        n = 0;
        while (stall_o && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (stall_o) begin
            tests++; fails++;
            $display("FAIL stall_timeout: stall still high after %0d cycles", n);
        end
        // DONE cycle: a request here must be ignored
        if (mode == 2 && $urandom_range(0, 1) == 1) begin
            req_i = 1'b1; we_i = 1'($urandom); size_i = 3'($urandom); addr_i = $urandom;
        end
        @(posedge clk_i); #1;
        req_i = 1'b0;
    endtask

    // monitor: sample on the falling edge
    int run = 0;
    bit prev_stall = 1'b0;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            run = 0;
            prev_stall = 1'b0;
        end else begin
            if (stall_o) begin
                run++;
            end else if (prev_stall) begin
                check("stall_len", 32'(run), 32'(LAT + 1));
                if (exp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
                else check("rdata_done", rdata_o, exp_q.pop_front());
                run = 0;
            end
            if (misalign_o) begin
                check("misalign_stall", {31'd0, stall_o}, 32'd0);
                if (mis_q.size() == 0) check("misalign_unexpected", 32'd1, 32'd0);
                else check("misalign_rdata", rdata_o, mis_q.pop_front());
            end
            prev_stall = stall_o;
        end
    end

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = '0; addr_i = '0; wdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_rdata", rdata_o, 32'd0);
        check("reset_stall", {31'd0, stall_o}, 32'd0);
        check("reset_misalign", {31'd0, misalign_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        for (int w = 0; w < DEPTH; w++) access(1'b1, 3'd2, 32'(w * 4), $urandom, 0);

        access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
        access(1'b0, 3'd2, 32'h10, 32'h0, 0);

        access(1'b1, 3'd0, 32'h21, 32'h00000080, 0);
        access(1'b0, 3'd0, 32'h21, 32'h0, 0);
        access(1'b0, 3'd4, 32'h21, 32'h0, 0);
        access(1'b0, 3'd1, 32'h20, 32'h0, 0);
        access(1'b0, 3'd5, 32'h20, 32'h0, 0);
        access(1'b0, 3'd0, 32'h20, 32'h0, 0);

        access(1'b0, 3'd2, 32'h12, 32'h0, 0);
        access(1'b1, 3'd1, 32'h13, 32'hCAFEF00D, 0);
        access(1'b0, 3'd3, 32'h10, 32'h0, 0);
        access(1'b0, 3'd2, 32'h10, 32'h0, 0);

        access(1'b1, 3'd2, 32'h400, 32'h12345678, 0);
        access(1'b0, 3'd2, 32'h000, 32'h0, 0);

        access(1'b1, 3'd2, 32'h14, 32'h5555AAAA, 0);
        access(1'b0, 3'd2, 32'h10, 32'h0, 1);

        // reset during the first BUSY cycle of a store
        access(1'b1, 3'd2, 32'h40, 32'h11111111, 0);
        we_i = 1'b1; size_i = 3'd2; addr_i = 32'h40; wdata_i = 32'hAAAAAAAA; req_i = 1'b1;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check("reset_mid_stall", {31'd0, stall_o}, 32'd0);
        check("reset_mid_rdata", rdata_o, 32'd0);
        last_rd = '0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        access(1'b0, 3'd2, 32'h40, 32'h0, 0);

        for (int k = 0; k < 250; k++) begin
            logic [2:0]  sz = 3'($urandom_range(0, 7));
            logic [31:0] ad = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz[1:0] == 2'd2) ad[1:0] = 2'b00;
                if (sz[1:0] == 2'd1) ad[0] = 1'b0;
            end
            access(1'($urandom), sz, ad, $urandom, 2);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i); #1;
            end
        end

        repeat (3) @(posedge clk_i);
        #1;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("mis_q_drained", 32'(mis_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
